// File: rtl/spi_master.sv
// spi_master: 16-bit full-duplex SPI master, mode 3, MSB first.
// Free-running SCLK divider, one-cycle write strobe, sticky done flag.
module spi_master #(
  parameter int SCLK_DIV = 32,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int DIVW = $clog2(SCLK_DIV);
  localparam int CNTW = $clog2(DATA_W);

  localparam logic [DIVW-1:0] DIV_LOAD =
    DIVW'(3 * SCLK_DIV / 4 - 1);
  localparam logic [DIVW-1:0] DIV_SMPL =
    DIVW'(SCLK_DIV / 2 - 1);
  localparam logic [DIVW-1:0] DIV_SHFT =
    DIVW'(SCLK_DIV - 1);
  localparam logic [CNTW-1:0] CNT_LAST =
    CNTW'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shft_q;
  logic [DIVW-1:0]   div_q;
  logic [DIVW-1:0]   div_d;
  logic [CNTW-1:0]   cnt_q;
  logic              porch_q;
  logic              miso_q;
  logic              done_q;
  logic              ss_n_q;
  logic              sclk_q;

  assign div_d = div_q + DIVW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shft_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      porch_q <= 1'b0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wrt) begin
            state_q <= ACTIVE;
            shft_q  <= cmd;
            div_q   <= DIV_LOAD;
            cnt_q   <= '0;
            porch_q <= 1'b0;
            done_q  <= 1'b0;
            ss_n_q  <= 1'b0;
            sclk_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          div_q  <= div_d;
          sclk_q <= div_d[DIVW-1];
          if (div_q == DIV_SMPL) begin
            miso_q <= MISO;
          end
          if (div_q == DIV_SHFT) begin
            // first wrap only closes the front porch
            if (!porch_q) begin
              porch_q <= 1'b1;
            end else begin
              shft_q <= {shft_q[DATA_W-2:0], miso_q};
              cnt_q  <= cnt_q + CNTW'(1);
              if (cnt_q == CNT_LAST) begin
                state_q <= IDLE;
                ss_n_q  <= 1'b1;
                done_q  <= 1'b1;
                sclk_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done    = done_q;
  assign rd_data = shft_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = shft_q[DATA_W-1];

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with a mode-3
// slave model; per-scenario tasks with inline comparisons.
module tb_spi_master;

  logic        clk;
  logic        rst;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_cmp;
  int n_bad;

  spi_master #(
    .SCLK_DIV(32),
    .DATA_W  (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wrt    (wrt),
    .cmd    (cmd),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave: loads on SS_n fall, drives on SCLK fall, samples on rise
  logic [15:0] slave_tx_next;
  logic [15:0] slave_tx;
  logic [15:0] slave_rx;
  int          slave_n;
  logic        ss_prev;
  logic        sclk_prev;

  initial begin
    MISO      = 1'b0;
    ss_prev   = 1'b1;
    sclk_prev = 1'b1;
    slave_tx  = 16'h0;
    slave_rx  = 16'h0;
    slave_n   = 0;
  end

  always @(SS_n, SCLK) begin
    if (ss_prev === 1'b1 && SS_n === 1'b0) begin
      slave_tx = slave_tx_next;
      slave_n  = 0;
      MISO     = slave_tx[15];
    end else if (SS_n === 1'b0) begin
      if (sclk_prev === 1'b0 && SCLK === 1'b1) begin
        slave_rx = {slave_rx[14:0], MOSI};
        slave_n++;
      end else if (sclk_prev === 1'b1 && SCLK === 1'b0
                   && slave_n > 0 && slave_n < 16) begin
        MISO = slave_tx[15 - slave_n];
      end
    end
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  int n_rise;
  int n_fall;
  int t_ss_fall;
  int t_ss_rise;
  int t_rise [16];
  int t_fall [17];
  bit done_hi;
  bit done_k1;
  bit done_at_end;
  bit timed_out;

  task automatic do_frame(input logic [15:0] c,
                          input bit now,
                          input bit busy,
                          input int abort_rise);
    logic pss;
    logic psc;
    n_rise      = 0;
    n_fall      = 0;
    t_ss_fall   = -1;
    t_ss_rise   = -1;
    done_hi     = 1'b0;
    done_k1     = 1'b1;
    done_at_end = 1'b0;
    timed_out   = 1'b1;
    if (!now) @(negedge clk);
    cmd = c;
    wrt = 1'b1;
    pss = SS_n;
    psc = SCLK;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      wrt = 1'b0;
      if (k == 1) done_k1 = done;
      if (pss && !SS_n) t_ss_fall = k;
      if (psc && !SCLK) begin
        if (n_fall < 17) t_fall[n_fall] = k;
        n_fall++;
      end
      if (!psc && SCLK) begin
        if (n_rise < 16) t_rise[n_rise] = k;
        n_rise++;
        if (busy && (n_rise == 3 || n_rise == 10)) begin
          cmd = 16'hFFFF;
          wrt = 1'b1;
        end
        if (abort_rise != 0 && n_rise == abort_rise) begin
          rst       = 1'b1;
          timed_out = 1'b0;
          break;
        end
      end
      if (!SS_n && done) done_hi = 1'b1;
      if (!pss && SS_n) begin
        t_ss_rise   = k;
        done_at_end = done;
        timed_out   = 1'b0;
        break;
      end
      pss = SS_n;
      psc = SCLK;
    end
  endtask

  task automatic test_reset;
    int toggles;
    int ss_low;
    logic psc;
    rst = 1'b1;
    wrt = 1'b0;
    cmd = 16'h0;
    slave_tx_next = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (SS_n !== 1'b1) begin n_bad++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
    n_cmp++; if (SCLK !== 1'b1) begin n_bad++; $display("FAIL rst_sclk: got %b want 1", SCLK); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
    n_cmp++; if (MOSI !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
    toggles = 0;
    ss_low  = 0;
    psc     = SCLK;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SCLK !== psc) toggles++;
      if (SS_n !== 1'b1) ss_low++;
      psc = SCLK;
    end
    n_cmp++; if (toggles !== 0) begin n_bad++; $display("FAIL idle_sclk_toggles: got %0d want 0", toggles); end
    n_cmp++; if (ss_low !== 0) begin n_bad++; $display("FAIL idle_ss_low: got %0d want 0", ss_low); end
  endtask

  task automatic test_basic;
    slave_tx_next = 16'hA5C3;
    do_frame(16'h63AC, 1'b0, 1'b0, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
    n_cmp++; if (slave_rx !== 16'h63AC) begin n_bad++; $display("FAIL basic_slave_rx: got %h want 63ac", slave_rx); end
    n_cmp++; if (rd_data !== 16'hA5C3) begin n_bad++; $display("FAIL basic_rd_data: got %h want a5c3", rd_data); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (n_rise !== 16) begin n_bad++; $display("FAIL basic_rises: got %0d want 16", n_rise); end
    n_cmp++; if (done_k1 !== 1'b0) begin n_bad++; $display("FAIL basic_done_clear: got %b want 0", done_k1); end
  endtask

  task automatic test_timing;
    n_cmp++; if (t_ss_fall !== 1) begin n_bad++; $display("FAIL tm_ss_fall: got %0d want 1", t_ss_fall); end
    n_cmp++; if (t_fall[0] - t_ss_fall !== 9) begin n_bad++; $display("FAIL tm_porch: got %0d want 9", t_fall[0] - t_ss_fall); end
    n_cmp++; if (n_fall !== 16) begin n_bad++; $display("FAIL tm_falls: got %0d want 16", n_fall); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++; if (t_rise[j] - t_fall[j] !== 16) begin n_bad++; $display("FAIL tm_low_%0d: got %0d want 16", j, t_rise[j] - t_fall[j]); end
    end
    for (int j = 0; j < 15; j++) begin
      n_cmp++; if (t_fall[j+1] - t_rise[j] !== 16) begin n_bad++; $display("FAIL tm_high_%0d: got %0d want 16", j, t_fall[j+1] - t_rise[j]); end
    end
    n_cmp++; if (t_ss_rise - t_ss_fall !== 521) begin n_bad++; $display("FAIL tm_ss_low: got %0d want 521", t_ss_rise - t_ss_fall); end
    n_cmp++; if (t_ss_rise - t_rise[15] !== 16) begin n_bad++; $display("FAIL tm_tail: got %0d want 16", t_ss_rise - t_rise[15]); end
    n_cmp++; if (done_at_end !== 1'b1) begin n_bad++; $display("FAIL tm_done_with_ss: got %b want 1", done_at_end); end
    n_cmp++; if (done_hi !== 1'b0) begin n_bad++; $display("FAIL tm_done_in_frame: got %b want 0", done_hi); end
  endtask

  task automatic test_back_to_back;
    slave_tx_next = slave_rx;
    do_frame(16'h1234, 1'b1, 1'b0, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: got %b want 0", timed_out); end
    n_cmp++; if (t_ss_fall !== 1) begin n_bad++; $display("FAIL b2b_accept: got %0d want 1", t_ss_fall); end
    n_cmp++; if (done_k1 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_clear: got %b want 0", done_k1); end
    n_cmp++; if (done_hi !== 1'b0) begin n_bad++; $display("FAIL b2b_done_in_frame: got %b want 0", done_hi); end
    n_cmp++; if (slave_rx !== 16'h1234) begin n_bad++; $display("FAIL b2b_slave_rx: got %h want 1234", slave_rx); end
    n_cmp++; if (rd_data !== 16'h63AC) begin n_bad++; $display("FAIL b2b_rd_data: got %h want 63ac", rd_data); end
  endtask

  task automatic test_busy_write;
    int ss_low;
    slave_tx_next = 16'h3C96;
    do_frame(16'h0F0F, 1'b0, 1'b1, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL busy_timeout: got %b want 0", timed_out); end
    n_cmp++; if (slave_rx !== 16'h0F0F) begin n_bad++; $display("FAIL busy_mosi: got %h want 0f0f", slave_rx); end
    n_cmp++; if (n_rise !== 16) begin n_bad++; $display("FAIL busy_rises: got %0d want 16", n_rise); end
    n_cmp++; if (rd_data !== 16'h3C96) begin n_bad++; $display("FAIL busy_rd_data: got %h want 3c96", rd_data); end
    ss_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SS_n !== 1'b1) ss_low++;
    end
    n_cmp++; if (ss_low !== 0) begin n_bad++; $display("FAIL busy_second_frame: got %0d want 0", ss_low); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL busy_done_sticky: got %b want 1", done); end
  endtask

  task automatic test_reset_mid;
    slave_tx_next = 16'hBEEF;
    do_frame(16'h5555, 1'b0, 1'b0, 5);
    n_cmp++; if (n_rise !== 5) begin n_bad++; $display("FAIL mid_rises: got %0d want 5", n_rise); end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (SS_n !== 1'b1) begin n_bad++; $display("FAIL mid_ss_n: got %b want 1", SS_n); end
    n_cmp++; if (SCLK !== 1'b1) begin n_bad++; $display("FAIL mid_sclk: got %b want 1", SCLK); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL mid_rd_data: got %h want 0000", rd_data); end
    slave_tx_next = 16'h9669;
    do_frame(16'h8001, 1'b0, 1'b0, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL post_timeout: got %b want 0", timed_out); end
    n_cmp++; if (slave_rx !== 16'h8001) begin n_bad++; $display("FAIL post_slave_rx: got %h want 8001", slave_rx); end
    n_cmp++; if (rd_data !== 16'h9669) begin n_bad++; $display("FAIL post_rd_data: got %h want 9669", rd_data); end
    n_cmp++; if (n_rise !== 16) begin n_bad++; $display("FAIL post_rises: got %0d want 16", n_rise); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL post_done: got %b want 1", done); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    wrt   = 1'b0;
    cmd   = 16'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_timing();
    test_back_to_back();
    test_busy_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
